// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit direction counter
// encoding and its saturating update.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  localparam bht_ctr_t CTR_RESET = WNT;
  localparam bht_ctr_t CTR_ALLOC = WT;

  // Saturating step toward taken (up) or not-taken (down).
  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = CTR_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count enabled events, holding at the maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {WIDTH{1'b0}};
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1'b1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup at IF, table
// update and mispredict redirect from EX, plus saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(3'd4);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    bht_ctr_t         ctr;
  } btb_entry_t;

  btb_entry_t       btb_r [ENTRIES];

  logic [IDX_W-1:0] if_idx_s;
  logic [TAG_W-1:0] if_tag_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic [TAG_W-1:0] ex_tag_s;
  btb_entry_t       lookup_s;
  btb_entry_t       ex_entry_s;
  btb_entry_t       upd_entry_s;
  logic             hit_s;
  logic             pred_taken_s;
  logic             ex_hit_s;
  logic             upd_we_s;
  logic             mispredict_s;

  assign if_idx_s = if_pc[IDX_W+1:2];
  assign if_tag_s = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx_s = ex_pc[IDX_W+1:2];
  assign ex_tag_s = ex_pc[PC_W-1:IDX_W+2];

  // IF lookup reads registered state only, so a same-cycle update is not seen.
  always_comb begin
    lookup_s     = btb_r[if_idx_s];
    hit_s        = lookup_s.valid && (lookup_s.tag == if_tag_s);
    pred_taken_s = hit_s && ((lookup_s.ctr == WT) || (lookup_s.ctr == ST));
    if (pred_taken_s) begin
      pred_target = lookup_s.target;
    end else begin
      pred_target = if_pc + PC_STEP;
    end
  end

  assign pred_taken = pred_taken_s;

  // Next value of the entry addressed by the resolving EX branch.
  always_comb begin
    ex_entry_s  = btb_r[ex_idx_s];
    ex_hit_s    = ex_entry_s.valid && (ex_entry_s.tag == ex_tag_s);
    upd_entry_s = ex_entry_s;
    upd_we_s    = 1'b0;
    if (ex_valid && ex_hit_s) begin
      upd_we_s        = 1'b1;
      upd_entry_s.ctr = ctr_next(ex_entry_s.ctr, ex_taken);
      if (ex_taken) begin
        upd_entry_s.target = ex_target;
      end else begin
        upd_entry_s.target = ex_entry_s.target;
      end
    end else if (ex_valid && ex_taken) begin
      upd_we_s           = 1'b1;
      upd_entry_s.valid  = 1'b1;
      upd_entry_s.tag    = ex_tag_s;
      upd_entry_s.target = ex_target;
      upd_entry_s.ctr    = CTR_ALLOC;
    end else begin
      upd_we_s = 1'b0;
    end
  end

  // Table storage; reset wins over any EX update in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_r[i].valid  <= 1'b0;
        btb_r[i].tag    <= {TAG_W{1'b0}};
        btb_r[i].target <= {PC_W{1'b0}};
        btb_r[i].ctr    <= CTR_RESET;
      end
    end else if (upd_we_s) begin
      btb_r[ex_idx_s] <= upd_entry_s;
    end
  end

  assign mispredict_s = ex_valid &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target)));
  assign redirect     = mispredict_s && !reset;
  assign redirect_pc  = ex_taken ? ex_target : (ex_pc + PC_STEP);

  sat_counter #(.WIDTH(CNT_W)) u_stat_branches (
    .clk   (clk),
    .reset (reset),
    .en    (ex_valid),
    .count (stat_branches)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stat_mispredicts (
    .clk   (clk),
    .reset (reset),
    .en    (mispredict_s),
    .count (stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Scenario bench for branch_predictor; a second instance with 4-bit stats
// shares the stimulus to exercise counter saturation.
module tb_branch_predictor;

  localparam int SEL_PT = 0, SEL_PTGT = 1, SEL_RD = 2, SEL_RDPC = 3;
  localparam int SEL_SB = 4, SEL_SM = 5, SEL_SSB = 6, SEL_SSM = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] if_pc;
  logic       ex_valid, ex_taken, ex_pred_taken;
  logic [8:0] ex_pc, ex_target, ex_pred_target;

  logic        pred_taken, redirect;
  logic [8:0]  pred_target, redirect_pc;
  logic [15:0] stat_branches, stat_mispredicts;
  logic        s_pred_taken, s_redirect;
  logic [8:0]  s_pred_target, s_redirect_pc;
  logic [3:0]  s_branches, s_mispredicts;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] value;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [15:0] got;
  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.PC_W(9), .ENTRIES(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor #(.PC_W(9), .ENTRIES(16), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect(s_redirect), .redirect_pc(s_redirect_pc),
    .stat_branches(s_branches), .stat_mispredicts(s_mispredicts)
  );

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_PT:   return {15'd0, pred_taken};
      SEL_PTGT: return {7'd0, pred_target};
      SEL_RD:   return {15'd0, redirect};
      SEL_RDPC: return {7'd0, redirect_pc};
      SEL_SB:   return stat_branches;
      SEL_SM:   return stat_mispredicts;
      SEL_SSB:  return {12'd0, s_branches};
      SEL_SSM:  return {12'd0, s_mispredicts};
      default:  return 16'hFFFF;
    endcase
  endfunction

  task automatic push(input string name, input int sel, input logic [15:0] value);
    exp_t x;
    x.name = name; x.sel = sel; x.value = value;
    sb.push_back(x);
  endtask

  task automatic set_ex(input logic v, input logic [8:0] pc, input logic tk,
                        input logic [8:0] tgt, input logic ptk, input logic [8:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic test_reset;
    reset = 1'b1; if_pc = 9'h010;
    set_ex(1'b1, 9'h010, 1'b1, 9'h040, 1'b0, 9'h014);
    @(posedge clk); #1;
    push("rst_redirect_forced0", SEL_RD, 16'd0);
    push("rst_pred_taken", SEL_PT, 16'd0);
    push("rst_pred_target", SEL_PTGT, 16'h014);
    push("rst_stat_branches", SEL_SB, 16'd0);
    push("rst_stat_mispredicts", SEL_SM, 16'd0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_ex(1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000);
    push("rst_ex_ignored_branches", SEL_SB, 16'd0);
    push("rst_ex_ignored_mispredicts", SEL_SM, 16'd0);
    push("rst_ex_ignored_lookup", SEL_PT, 16'd0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
  endtask

  task automatic test_allocate;
    @(posedge clk); #1;
    if_pc = 9'h010;
    set_ex(1'b1, 9'h010, 1'b1, 9'h040, 1'b0, 9'h014);
    push("alloc_redirect", SEL_RD, 16'd1);
    push("alloc_redirect_pc", SEL_RDPC, 16'h040);
    push("alloc_pre_update_lookup", SEL_PT, 16'd0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
    @(posedge clk); #1;
    set_ex(1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000);
    push("alloc_pred_taken", SEL_PT, 16'd1);
    push("alloc_pred_target", SEL_PTGT, 16'h040);
    push("alloc_stat_branches", SEL_SB, 16'd1);
    push("alloc_stat_mispredicts", SEL_SM, 16'd1);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
  endtask

  // Counter goes 10 -> 11 (three times), then two not-taken: 10 then 01.
  task automatic test_back_to_back;
    if_pc = 9'h010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_ex(1'b1, 9'h010, 1'b1, 9'h040, 1'b1, 9'h040);
      push("hyst_correct_no_redirect", SEL_RD, 16'd0);
      push("hyst_correct_pred", SEL_PT, 16'd1);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sel); n_checks++;
        if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      set_ex(1'b1, 9'h010, 1'b0, 9'h040, 1'b1, 9'h040);
      push("hyst_nt_redirect", SEL_RD, 16'd1);
      push("hyst_nt_redirect_pc", SEL_RDPC, 16'h014);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sel); n_checks++;
        if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
      end
      @(posedge clk); #1;
      set_ex(1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000);
      push("hyst_after_nt_pred", SEL_PT, (i == 0) ? 16'd1 : 16'd0);
      push("hyst_after_nt_target", SEL_PTGT, (i == 0) ? 16'h040 : 16'h014);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sel); n_checks++;
        if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
      end
    end
    push("hyst_stat_branches", SEL_SB, 16'd6);
    push("hyst_stat_mispredicts", SEL_SM, 16'd3);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
  endtask

  // 0x050 shares index 4 with 0x010 but has tag 1, so it replaces the entry.
  task automatic test_alias;
    @(posedge clk); #1;
    if_pc = 9'h050;
    set_ex(1'b1, 9'h050, 1'b1, 9'h100, 1'b0, 9'h054);
    push("alias_redirect_pc", SEL_RDPC, 16'h100);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
    @(posedge clk); #1;
    set_ex(1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000);
    if_pc = 9'h010;
    push("alias_old_misses", SEL_PT, 16'd0);
    push("alias_old_target", SEL_PTGT, 16'h014);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
    @(posedge clk); #1;
    if_pc = 9'h050;
    push("alias_new_pred", SEL_PT, 16'd1);
    push("alias_new_target", SEL_PTGT, 16'h100);
    push("alias_stat_branches", SEL_SB, 16'd7);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
  endtask

  task automatic test_target_wrap;
    @(posedge clk); #1;
    set_ex(1'b1, 9'h050, 1'b1, 9'h080, 1'b1, 9'h040);
    push("tgt_mismatch_redirect", SEL_RD, 16'd1);
    push("tgt_mismatch_redirect_pc", SEL_RDPC, 16'h080);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
    @(posedge clk); #1;
    if_pc = 9'h1FC;
    set_ex(1'b1, 9'h1FC, 1'b0, 9'h000, 1'b1, 9'h020);
    push("wrap_redirect", SEL_RD, 16'd1);
    push("wrap_redirect_pc", SEL_RDPC, 16'h000);
    push("wrap_pred_target", SEL_PTGT, 16'h000);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
    @(posedge clk); #1;
    set_ex(1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000);
    push("wrap_nt_miss_no_alloc", SEL_PT, 16'd0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
    @(posedge clk); #1;
    if_pc = 9'h050;
    push("tgt_updated", SEL_PTGT, 16'h080);
    push("tgt_stat_branches", SEL_SB, 16'd9);
    push("tgt_stat_mispredicts", SEL_SM, 16'd6);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
  endtask

  task automatic test_simultaneous;
    @(posedge clk); #1;
    if_pc = 9'h010;
    set_ex(1'b1, 9'h010, 1'b1, 9'h0C0, 1'b0, 9'h014);
    push("simul_old_pred", SEL_PT, 16'd0);
    push("simul_old_target", SEL_PTGT, 16'h014);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
    @(posedge clk); #1;
    set_ex(1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000);
    push("simul_new_pred", SEL_PT, 16'd1);
    push("simul_new_target", SEL_PTGT, 16'h0C0);
    push("simul_stat_branches", SEL_SB, 16'd10);
    push("simul_stat_mispredicts", SEL_SM, 16'd7);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
  endtask

  task automatic test_reset_midrun;
    @(posedge clk); #1;
    reset = 1'b1;
    set_ex(1'b1, 9'h050, 1'b1, 9'h0A0, 1'b0, 9'h054);
    push("midrst_redirect_forced0", SEL_RD, 16'd0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_ex(1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000);
    if_pc = 9'h010;
    push("midrst_lookup_010", SEL_PT, 16'd0);
    push("midrst_stat_branches", SEL_SB, 16'd0);
    push("midrst_stat_mispredicts", SEL_SM, 16'd0);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
    @(posedge clk); #1;
    if_pc = 9'h050;
    push("midrst_lookup_050", SEL_PT, 16'd0);
    push("midrst_target_050", SEL_PTGT, 16'h054);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      set_ex(1'b1, 9'h1FC, 1'b0, 9'h000, 1'b1, 9'h100);
      push("sat_redirect", SEL_RD, 16'd1);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sel); n_checks++;
        if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
      end
    end
    @(posedge clk); #1;
    set_ex(1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 9'h000);
    push("sat_wide_branches", SEL_SB, 16'd20);
    push("sat_wide_mispredicts", SEL_SM, 16'd20);
    push("sat_small_branches", SEL_SSB, 16'd15);
    push("sat_small_mispredicts", SEL_SSM, 16'd15);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = observe(e.sel); n_checks++;
      if (got !== e.value) begin n_fails++; $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.value); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_allocate();
    test_back_to_back();
    test_alias();
    test_target_wrap();
    test_simultaneous();
    test_reset_midrun();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage RISC-V pipeline.
- Replaces the fixed predict-not-taken / flush-in-EX scheme.
- The IF stage looks up the fetch PC in a direct-mapped BTB with 2-bit saturating counters and gets a predicted next PC.
- The EX stage reports the resolved branch. The block updates its tables, raises redirect/flush on a misprediction, and keeps saturating performance counters.

Parameters:
PC_W, 9, program counter width (byte address)
ENTRIES, 16, BTB/BHT entries, power of two, >= 2
CNT_W, 16, width of the statistics counters
(derived: IDX_W = $clog2(ENTRIES); TAG_W = PC_W-IDX_W-2; PC_W >= IDX_W+3 is required)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
if_pc  in  PC_W  PC being fetched
pred_taken  out  1  prediction: branch at if_pc is taken
pred_target  out  PC_W  predicted next fetch PC
ex_valid  in  1  EX holds a resolved branch/jump this cycle
ex_pc  in  PC_W  PC of the EX branch
ex_taken  in  1  actual direction
ex_target  in  PC_W  actual taken target
ex_pred_taken  in  1  prediction made for this instruction at IF (carried down the pipe)
ex_pred_target  in  PC_W  predicted target made at IF
redirect  out  1  mispredict: flush IF/ID and ID/EX, load redirect_pc
redirect_pc  out  PC_W  corrected fetch PC
stat_branches  out  CNT_W  resolved branches since reset
stat_mispredicts  out  CNT_W  mispredictions since reset

Behaviour:
- Index is pc[IDX_W+1:2]; tag is pc[PC_W-1:IDX_W+2].
- Per-entry state: valid, tag, target[PC_W], ctr[2].
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset (sync): all valid=0, all ctr=01, stats=0. redirect is forced 0 while reset=1. ex_valid is ignored in the reset cycle.
- Lookup (combinational from registered state, zero latency):
  - hit = valid[i] && tag[i]==tag(if_pc).
  - pred_taken = hit && ctr[i][1].
  - pred_target = pred_taken ? target[i] : if_pc+4.
- Mispredict (combinational): mispredict = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target)).
- redirect = mispredict && !reset.
- redirect_pc = ex_taken ? ex_target : ex_pc+4.
- All PC arithmetic is modulo 2^PC_W; 0x1FC+4 wraps to 0x000 for PC_W=9.
- Update at the rising edge when ex_valid:
  - Entry hit (valid and tag match): ctr saturating +1 if taken, -1 if not taken. If taken, target <= ex_target.
  - Entry miss and taken: allocate or replace: valid=1, tag, target=ex_target, ctr=10.
  - Entry miss and not taken: no table change.
- Lookup and update on the same index in the same cycle: lookup returns pre-update values. There is no bypass; new values are visible the next cycle.
- Stats at the edge when ex_valid:
  - stat_branches += 1.
  - stat_mispredicts += 1 if mispredict.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Reset asserted mid-run: tables and stats are cleared on that edge, regardless of ex_valid.
- No stall input. A load-use stall inserts a bubble with ex_valid=0, so no update happens for it.

Decomposition:
- Package bp_pkg holds:
  - typedef enum logic [1:0] bht_ctr_t {SNT, WNT, WT, ST}.
  - typedef struct btb_entry_t {valid, tag, target, ctr}, parametrised through the module using it.
  - Constants CTR_RESET=WNT and CTR_ALLOC=WT.
- One sub-module, sat_counter (WIDTH, en, reset, count; saturating increment), instantiated twice for the statistics.

Test Plan (PC_W=9, ENTRIES=16, CNT_W=16 unless stated):
1. Reset, then if_pc=0x010 -> pred_taken=0, pred_target=0x014, redirect=0, both stats 0.
2. ex_valid, ex_pc=0x010, ex_taken=1, ex_target=0x040, ex_pred_taken=0 -> same cycle redirect=1, redirect_pc=0x040. Next cycle if_pc=0x010 gives pred_taken=1, pred_target=0x040; stat_branches=1, stat_mispredicts=1.
3. Hysteresis: 3 more taken at 0x010 (ctr=11), then one not-taken -> pred_taken still 1 (ctr 10). Second not-taken -> pred_taken=0, pred_target=0x014. Correctly predicted cycles show redirect=0.
4. Alias: with 0x010 allocated, resolve ex_pc=0x050 (same index 4, tag 1) taken to 0x100 -> if_pc=0x010 misses (pred_taken=0), if_pc=0x050 gives pred_target=0x100.
5. Target mismatch and wrap:
   - ex_taken=1, ex_pred_taken=1, ex_pred_target=0x040, ex_target=0x080 -> redirect=1, redirect_pc=0x080.
   - ex_pc=0x1FC, ex_taken=0, ex_pred_taken=1 -> redirect_pc=0x000.
6. Simultaneous and reset:
   - Same-cycle lookup/update on index 4 -> old prediction is returned; new one appears next cycle.
   - reset pulsed mid-run -> all lookups miss, stats=0.
   - With CNT_W=4, 20 mispredicting branches -> both stats=15.
